// File: rtl/mem_bus_defs.sv
// ============================================================================
// mem_bus_defs
//   Shared encodings for the block mover and its memory-side bus.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package mem_bus_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // Memory enables are active low
    localparam logic MEM_ON    = 1'b0;
    localparam logic MEM_OFF   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_xfer_counter.sv
// ============================================================================
// mem_xfer_counter
//   Source/destination pointers, remaining-word count and words-written tally.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mem_xfer_counter #(
    parameter int AddrWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [AddrWidth-1:0] src_base,
    input  logic [AddrWidth-1:0] dst_base,
    input  logic [AddrWidth:0]   length,
    output logic [AddrWidth-1:0] src_ptr,
    output logic [AddrWidth-1:0] dst_ptr,
    output logic [AddrWidth:0]   words_done,
    output logic                 last
);

    localparam logic [AddrWidth-1:0] C_ONE_A = AddrWidth'(1);
    localparam logic [AddrWidth:0]   C_ONE_R = (AddrWidth + 1)'(1);

    logic [AddrWidth:0] r_remaining;

    // Pointers wrap naturally at 2^AddrWidth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr     <= '0;
            dst_ptr     <= '0;
            words_done  <= '0;
            r_remaining <= '0;
        end else if (load) begin
            src_ptr     <= src_base;
            dst_ptr     <= dst_base;
            words_done  <= '0;
            r_remaining <= length;
        end else if (step) begin
            src_ptr     <= src_ptr + C_ONE_A;
            dst_ptr     <= dst_ptr + C_ONE_A;
            words_done  <= words_done + C_ONE_R;
            r_remaining <= r_remaining - C_ONE_R;
        end
    end

    assign last = (r_remaining == C_ONE_R);

endmodule

`default_nettype wire

// File: rtl/mem_block_mover.sv
// ============================================================================
// mem_block_mover
//   Block copy / block fill initiator for an active-low single-port BRAM.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mem_block_mover
    import mem_bus_defs::*;
#(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 Start,
    input  logic                 Mode,
    input  logic [AddrWidth-1:0] Src_Addr,
    input  logic [AddrWidth-1:0] Dst_Addr,
    input  logic [AddrWidth:0]   Length,
    input  logic [DataWidth-1:0] Fill_Value,
    input  logic                 Abort,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Aborted,
    output logic [AddrWidth:0]   Words_Done,
    output logic [AddrWidth-1:0] Mem_Address,
    output logic [DataWidth-1:0] Mem_DIn,
    input  logic [DataWidth-1:0] Mem_DOut,
    output logic                 Mem_Write_EN,
    output logic                 Mem_En
);

    localparam logic [AddrWidth-1:0] C_ONE_A = AddrWidth'(1);

    state_t               r_state;
    logic                 r_mode;
    logic [DataWidth-1:0] r_fill;

    logic                 w_load;
    logic                 w_step;
    logic [AddrWidth-1:0] w_src_ptr;
    logic [AddrWidth-1:0] w_dst_ptr;
    logic                 w_last;

    assign w_load = (r_state == IDLE) && Start;
    assign w_step = (r_state == WR);

    mem_xfer_counter #(
        .AddrWidth (AddrWidth)
    ) u_counter (
        .clk        (Clk),
        .rst_n      (Reset_N),
        .load       (w_load),
        .step       (w_step),
        .src_base   (Src_Addr),
        .dst_base   (Dst_Addr),
        .length     (Length),
        .src_ptr    (w_src_ptr),
        .dst_ptr    (w_dst_ptr),
        .words_done (Words_Done),
        .last       (w_last)
    );

    // Memory-side outputs are set for the state being entered, so they are
    // already stable when the memory samples on the following negedge.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state      <= IDLE;
            r_mode       <= MODE_COPY;
            r_fill       <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Aborted      <= 1'b0;
            Mem_Address  <= '0;
            Mem_DIn      <= '0;
            Mem_En       <= MEM_OFF;
            Mem_Write_EN <= MEM_OFF;
        end else begin
            Done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_mode  <= Mode;
                        r_fill  <= Fill_Value;
                        Aborted <= 1'b0;
                        if (Length == '0) begin
                            r_state <= DONE;
                            Done    <= 1'b1;
                        end else if (Mode == MODE_COPY) begin
                            r_state      <= RD;
                            Busy         <= 1'b1;
                            Mem_En       <= MEM_ON;
                            Mem_Write_EN <= MEM_OFF;
                            Mem_Address  <= Src_Addr;
                        end else begin
                            r_state      <= WR;
                            Busy         <= 1'b1;
                            Mem_En       <= MEM_ON;
                            Mem_Write_EN <= MEM_ON;
                            Mem_Address  <= Dst_Addr;
                            Mem_DIn      <= Fill_Value;
                        end
                    end
                end
                RD: begin
                    if (Abort) begin
                        r_state      <= DONE;
                        Busy         <= 1'b0;
                        Done         <= 1'b1;
                        Aborted      <= 1'b1;
                        Mem_En       <= MEM_OFF;
                        Mem_Write_EN <= MEM_OFF;
                    end else begin
                        r_state      <= WR;
                        Mem_Write_EN <= MEM_ON;
                        Mem_Address  <= w_dst_ptr;
                        Mem_DIn      <= Mem_DOut;
                    end
                end
                WR: begin
                    if (Abort || w_last) begin
                        r_state      <= DONE;
                        Busy         <= 1'b0;
                        Done         <= 1'b1;
                        Aborted      <= Abort;
                        Mem_En       <= MEM_OFF;
                        Mem_Write_EN <= MEM_OFF;
                    end else if (r_mode == MODE_COPY) begin
                        r_state      <= RD;
                        Mem_Write_EN <= MEM_OFF;
                        Mem_Address  <= w_src_ptr + C_ONE_A;
                    end else begin
                        Mem_Address  <= w_dst_ptr + C_ONE_A;
                        Mem_DIn      <= r_fill;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_block_mover.sv
// ============================================================================
// tb_mem_block_mover
//   Directed bench for mem_block_mover with a negedge-registered BRAM model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_block_mover;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        Start = 1'b0;
    logic        Mode = 1'b0;
    logic [7:0]  Src_Addr = '0;
    logic [7:0]  Dst_Addr = '0;
    logic [8:0]  Length = '0;
    logic [15:0] Fill_Value = '0;
    logic        Abort = 1'b0;
    logic        Busy;
    logic        Done;
    logic        Aborted;
    logic [8:0]  Words_Done;
    logic [7:0]  Mem_Address;
    logic [15:0] Mem_DIn;
    logic [15:0] Mem_DOut;
    logic        Mem_Write_EN;
    logic        Mem_En;

    mem_block_mover #(.AddrWidth(8), .DataWidth(16)) dut (
        .Clk          (Clk),
        .Reset_N      (Reset_N),
        .Start        (Start),
        .Mode         (Mode),
        .Src_Addr     (Src_Addr),
        .Dst_Addr     (Dst_Addr),
        .Length       (Length),
        .Fill_Value   (Fill_Value),
        .Abort        (Abort),
        .Busy         (Busy),
        .Done         (Done),
        .Aborted      (Aborted),
        .Words_Done   (Words_Done),
        .Mem_Address  (Mem_Address),
        .Mem_DIn      (Mem_DIn),
        .Mem_DOut     (Mem_DOut),
        .Mem_Write_EN (Mem_Write_EN),
        .Mem_En       (Mem_En)
    );

    always #5 Clk = ~Clk;

    logic [15:0] mem  [256];
    logic [15:0] seed [256];
    logic [15:0] gold [256];
    logic        do_load = 1'b0;

    always @(negedge Clk) begin
        if (do_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed[i];
        end else if (Mem_En == 1'b0) begin
            if (Mem_Write_EN == 1'b0) mem[Mem_Address] <= Mem_DIn;
            else                      Mem_DOut <= mem[Mem_Address];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int mode;
        int src;
        int dst;
        int len;
        int fill;
        int abort_wr;
        int busy_start;
        int exp_cycles;
        int exp_words;
        int exp_aborted;
        int exp_en;
    } vec_t;

    vec_t vecs[8];

    task automatic load_mem();
        @(posedge Clk);
        do_load = 1'b1;
        @(posedge Clk);
        do_load = 1'b0;
        for (int i = 0; i < 256; i++) gold[i] = seed[i];
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cycles, en_cyc, wr_cyc, busy_cyc, done_cnt, mism, s, d;
        cycles = -1; en_cyc = 0; wr_cyc = 0; busy_cyc = 0; done_cnt = 0;
        load_mem();
        @(negedge Clk);
        Mode       = v.mode[0];
        Src_Addr   = 8'(v.src);
        Dst_Addr   = 8'(v.dst);
        Length     = 9'(v.len);
        Fill_Value = 16'(v.fill);
        Start      = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (v.busy_start != 0 && n == v.busy_start) begin
                Start = 1'b1; Mode = 1'b1; Src_Addr = 8'h80;
                Dst_Addr = 8'h90; Length = 9'd5; Fill_Value = 16'hDEAD;
            end
            if (Mem_En == 1'b0) en_cyc++;
            if (Mem_En == 1'b0 && Mem_Write_EN == 1'b0) wr_cyc++;
            if (Busy) busy_cyc++;
            Abort = (v.abort_wr != 0 && wr_cyc == v.abort_wr && Mem_Write_EN == 1'b0 && Mem_En == 1'b0);
            if (Done) begin
                done_cnt++;
                cycles = n;
                break;
            end
        end
        Start = 1'b0;
        Abort = 1'b0;
        chk($sformatf("v%0d done_cycle", idx), cycles, v.exp_cycles);
        chk($sformatf("v%0d aborted", idx), int'(Aborted), v.exp_aborted);
        for (int n = 0; n < 4; n++) begin
            @(negedge Clk);
            if (Done) done_cnt++;
            if (Mem_En == 1'b0) en_cyc++;
        end
        chk($sformatf("v%0d done_pulses", idx), done_cnt, 1);
        chk($sformatf("v%0d mem_en_cycles", idx), en_cyc, v.exp_en);
        chk($sformatf("v%0d busy_cycles", idx), busy_cyc, (v.exp_cycles > 0) ? v.exp_cycles - 1 : 0);
        chk($sformatf("v%0d words_done_held", idx), int'(Words_Done), v.exp_words);
        chk($sformatf("v%0d busy_after", idx), int'(Busy), 0);
        for (int i = 0; i < v.exp_words; i++) begin
            s = (v.src + i) % 256;
            d = (v.dst + i) % 256;
            gold[d] = (v.mode != 0) ? 16'(v.fill) : gold[s];
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) mism++;
        chk($sformatf("v%0d mem_mismatches", idx), mism, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"},       int'(Busy), 0);
        chk({tag, " done"},       int'(Done), 0);
        chk({tag, " aborted"},    int'(Aborted), 0);
        chk({tag, " words_done"}, int'(Words_Done), 0);
        chk({tag, " mem_en"},     int'(Mem_En), 1);
        chk({tag, " mem_wr_en"},  int'(Mem_Write_EN), 1);
        chk({tag, " mem_addr"},   int'(Mem_Address), 0);
        chk({tag, " mem_din"},    int'(Mem_DIn), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) seed[i] = {8'(i), ~8'(i)};
        seed[8'h10] = 16'hA001; seed[8'h11] = 16'hA002;
        seed[8'h12] = 16'hA003; seed[8'h13] = 16'hA004;

        //          mode src    dst    len  fill     abt bsy cyc  words ab en
        vecs[0] = '{0, 'h10, 'h40, 4,   'h0000, 0, 0, 9,   4,   0, 8};
        vecs[1] = '{1, 'h00, 'hFE, 3,   'h5A5A, 0, 0, 4,   3,   0, 3};
        vecs[2] = '{0, 'h20, 'h30, 0,   'h0000, 0, 0, 1,   0,   0, 0};
        vecs[3] = '{0, 'h20, 'h21, 3,   'h0000, 0, 0, 7,   3,   0, 6};
        vecs[4] = '{1, 'h00, 'h00, 256, 'h1234, 0, 0, 257, 256, 0, 256};
        vecs[5] = '{0, 'hFE, 'h80, 3,   'h0000, 0, 0, 7,   3,   0, 6};
        vecs[6] = '{0, 'h10, 'h60, 8,   'h0000, 3, 0, 7,   3,   1, 6};
        vecs[7] = '{0, 'h10, 'h40, 4,   'h0000, 0, 3, 9,   4,   0, 8};

        @(negedge Clk);
        chk_reset_vals("por");
        @(negedge Clk);
        Reset_N = 1'b1;

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Asynchronous reset in the middle of a copy
        load_mem();
        @(negedge Clk);
        Mode = 1'b0; Src_Addr = 8'h10; Dst_Addr = 8'h40; Length = 9'd4; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("mid busy", int'(Busy), 1);
        #2 Reset_N = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(posedge Clk);
        #1 chk("rst_held mem_en", int'(Mem_En), 1);
        chk("rst_held mem_wr_en", int'(Mem_Write_EN), 1);
        @(negedge Clk);
        Reset_N = 1'b1;
        @(negedge Clk);
        chk("post_rst done", int'(Done), 0);
        chk("post_rst mem_en", int'(Mem_En), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Bus initiator for the single-port, active-low-enabled BRAM (`Memory`). Drives that memory's Address, DIn, Write_EN and Mem_En, and consumes its negedge-registered DOut.
- Performs block copy (read→write) or block fill (write only) on request from the control/sequencer logic.
- Reports progress through a Busy/Done handshake.

Parameters:
- AddrWidth, 8, width of memory address; must match the attached `Memory`.
- DataWidth, 16, width of memory word; must match the attached `Memory`.

Ports:
- Clk  input  1  system clock; all outputs change on posedge.
- Reset_N  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request; sampled only in IDLE.
- Mode  input  1  0 = copy, 1 = fill; latched at Start.
- Src_Addr  input  AddrWidth  copy source base; latched at Start.
- Dst_Addr  input  AddrWidth  destination base; latched at Start.
- Length  input  AddrWidth+1  word count, 0..2^AddrWidth; latched at Start.
- Fill_Value  input  DataWidth  fill word; latched at Start.
- Abort  input  1  terminate the transfer early.
- Busy  output  1  high from the cycle after Start until Done.
- Done  output  1  one-cycle pulse at transfer end.
- Aborted  output  1  valid with Done; 1 if ended by Abort.
- Words_Done  output  AddrWidth+1  count of words written; holds its value after Done.
- Mem_Address  output  AddrWidth  to memory Address.
- Mem_DIn  output  DataWidth  to memory DIn.
- Mem_DOut  input  DataWidth  from memory DOut.
- Mem_Write_EN  output  1  active low.
- Mem_En  output  1  active low.

Behaviour:
- Reset (asynchronous, Reset_N=0): state IDLE, Busy=0, Done=0, Aborted=0, Words_Done=0, Mem_En=1, Mem_Write_EN=1, Mem_Address=0, Mem_DIn=0.
- Timing contract: all memory-side outputs are registered on posedge, so they are stable at the memory's negedge.
  - Read issued in cycle k: memory latches DOut at the mid-k negedge; block samples Mem_DOut at posedge k+1.
  - Write issued in cycle k: memory commits at the mid-k negedge.
- States: IDLE, RD, WR, DONE.
- IDLE: Mem_En=1, Mem_Write_EN=1. On Start:
  - latch inputs; clear Words_Done and Aborted.
  - Length=0 → DONE.
  - Mode=0 → RD.
  - Mode=1 → WR.
- RD (copy only): Mem_En=0, Mem_Write_EN=1, Mem_Address=src pointer. Next state WR. Mem_DOut is captured into data_q at the posedge leaving RD.
- WR: Mem_En=0, Mem_Write_EN=0, Mem_Address=dst pointer, Mem_DIn=data_q (copy) or fill latch (fill).
  - On exit: increment both pointers (mod 2^AddrWidth, wrap 0xFF→0x00) and Words_Done.
  - If remaining=1 → DONE; else → RD (copy) or WR (fill).
- DONE: Done=1 and Busy=0 for exactly one cycle, memory idle, then IDLE.
- Throughput: copy = 2 cycles/word; fill = 1 cycle/word. Start-to-Done = 2·Length+1 cycles (copy), Length+1 cycles (fill).
- Abort, sampled in RD or WR: the current WR still completes and is counted; an RD in progress is discarded. Then DONE with Aborted=1. Abort is ignored in IDLE and DONE.
- Start while Busy or in DONE: ignored, no effect.
- Length=2^AddrWidth: the whole memory is traversed, each word exactly once.
- Overlap: forward copy only. If Dst in (Src, Src+Length), already-written words are re-read; this is the defined behaviour, not an error.
- Reset mid-transfer: immediate return to reset values; a partial write is not guaranteed.

Decomposition:
- Shared package/header `mem_bus_defs`: state encodings (IDLE=2'd0, RD=2'd1, WR=2'd2, DONE=2'd3), MODE_COPY=1'b0, MODE_FILL=1'b1, and active-low constants MEM_ON=1'b0, MEM_OFF=1'b1.
- One sub-module `mem_xfer_counter`: holds the src/dst pointers, remaining count and Words_Done, with load/step inputs and a last flag. The FSM stays in mem_block_mover.

Test Plan:
- Reset: Reset_N low mid-copy → all outputs at reset values asynchronously; Mem_En=1 and Mem_Write_EN=1 while Reset_N is low.
- Copy: mem[0x10..0x13]=0xA001..0xA004; Start, Mode=0, Src=0x10, Dst=0x40, Len=4 → mem[0x40..0x43]=0xA001..0xA004; Done on cycle 9 after Start; Words_Done=4; Aborted=0.
- Fill with wrap: Mode=1, Dst=0xFE, Len=3, Fill_Value=0x5A5A → mem[0xFE], mem[0xFF], mem[0x00]=0x5A5A; mem[0x01] unchanged; Done on cycle 4.
- Zero length: Len=0 → Done the next cycle; no cycle with Mem_En=0; Words_Done=0.
- Abort: copy with Len=8, Abort asserted during the third WR → Words_Done=3, Aborted=1, only Dst..Dst+2 modified.
- Start while Busy: a second Start with different addresses during a copy → ignored; the first transfer's results are exact and Done pulses once.
